// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan slice.
// Mode encodings used by the top-level selection logic.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_counter.sv
// Dwell and channel-index counter for the scan mode of mux_scan.
// idx is the channel sampled on the current edge; wrap_next marks a return to 0.
module scan_counter #(
    parameter  int N_CH   = 4,
    parameter  int HOLD   = 1,
    localparam int SEL_W  = $clog2(N_CH),
    localparam int HOLD_W = $clog2(HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    output logic [SEL_W-1:0] idx,
    output logic             wrap_next
);

    localparam logic [SEL_W-1:0]  LAST    = SEL_W'(N_CH - 1);
    localparam logic [HOLD_W-1:0] DW_LAST = HOLD_W'(HOLD - 1);

    logic [SEL_W-1:0]  idx_q;
    logic [HOLD_W-1:0] dwell_q;
    logic [HOLD_W-1:0] dwell_cur;

    // A restart edge behaves as the first sample of channel 0.
    assign idx       = restart ? '0 : idx_q;
    assign dwell_cur = restart ? '0 : dwell_q;

    // Index 0 at dwell 0 is only reachable by wrapping once scan has started.
    assign wrap_next = !restart && (idx_q == '0) && (dwell_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            dwell_q <= '0;
        end else if (en) begin
            if (dwell_cur == DW_LAST) begin
                dwell_q <= '0;
                idx_q   <= (idx == LAST) ? '0 : idx + 1'b1;
            end else begin
                dwell_q <= dwell_cur + 1'b1;
                idx_q   <= idx;
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and timed scan mode.
// Outputs y, y_valid, sel_out, wrap and sel_err are all registered.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 1,
    parameter  int HOLD  = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [N_CH*W-1:0] data_in,
    output logic [W-1:0]      y,
    output logic              y_valid,
    output logic [SEL_W-1:0]  sel_out,
    output logic              wrap,
    output logic              sel_err
);

    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_CH);

    logic             prev_mode;
    logic             scan_en;
    logic             restart;
    logic             wrap_next;
    logic             sel_ok;
    logic [SEL_W-1:0] idx;

    assign scan_en = en && (mode == MODE_SCAN);
    assign restart = scan_en && (prev_mode == MODE_MANUAL);
    assign sel_ok  = {1'b0, sel_in} < N_LIM;

    scan_counter #(
        .N_CH (N_CH),
        .HOLD (HOLD)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (scan_en),
        .restart   (restart),
        .idx       (idx),
        .wrap_next (wrap_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_mode <= MODE_MANUAL;
            y         <= '0;
            y_valid   <= 1'b0;
            sel_out   <= '0;
            wrap      <= 1'b0;
            sel_err   <= 1'b0;
        end else if (!en) begin
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            prev_mode <= mode;
            sel_err   <= 1'b0;
            wrap      <= 1'b0;
            if (mode == MODE_SCAN) begin
                y       <= data_in[int'(idx)*W +: W];
                sel_out <= idx;
                y_valid <= 1'b1;
                wrap    <= wrap_next;
            end else if (sel_ok) begin
                y       <= data_in[int'(sel_in)*W +: W];
                sel_out <= sel_in;
                y_valid <= 1'b1;
            end else begin
                // Illegal select: flag it and publish no sample.
                y       <= '0;
                sel_out <= sel_in;
                y_valid <= 1'b0;
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three builds (4ch/hold1, 4ch/hold3, 5ch/hold2 W=4)
// on shared stimulus, checked against a position-based model every cycle.
module tb_mux_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [2:0]  sel_in;
    logic [19:0] data_in;

    logic       y0, y1;
    logic [3:0] y2;
    logic       v0, v1, v2;
    logic [1:0] s0, s1;
    logic [2:0] s2;
    logic       w0, w1, w2;
    logic       e0, e1, e2;

    always #5 clk = ~clk;

    mux_scan #(.N_CH(4), .W(1), .HOLD(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sel_in(sel_in[1:0]), .data_in(data_in[3:0]),
        .y(y0), .y_valid(v0), .sel_out(s0), .wrap(w0), .sel_err(e0)
    );

    mux_scan #(.N_CH(4), .W(1), .HOLD(3)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sel_in(sel_in[1:0]), .data_in(data_in[3:0]),
        .y(y1), .y_valid(v1), .sel_out(s1), .wrap(w1), .sel_err(e1)
    );

    mux_scan #(.N_CH(5), .W(4), .HOLD(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sel_in(sel_in), .data_in(data_in),
        .y(y2), .y_valid(v2), .sel_out(s2), .wrap(w2), .sel_err(e2)
    );

    localparam int NCHS [3] = '{4, 4, 5};
    localparam int WS   [3] = '{1, 1, 4};
    localparam int HS   [3] = '{1, 3, 2};
    localparam int SWS  [3] = '{2, 2, 3};

    logic [31:0] dy [3];
    logic [31:0] ds [3];
    logic        dv [3];
    logic        dw [3];
    logic        de [3];

    assign dy[0] = 32'(y0);
    assign dy[1] = 32'(y1);
    assign dy[2] = 32'(y2);
    assign ds[0] = 32'(s0);
    assign ds[1] = 32'(s1);
    assign ds[2] = 32'(s2);
    assign dv[0] = v0;
    assign dv[1] = v1;
    assign dv[2] = v2;
    assign dw[0] = w0;
    assign dw[1] = w1;
    assign dw[2] = w2;
    assign de[0] = e0;
    assign de[1] = e1;
    assign de[2] = e2;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: p counts scan samples since the last entry into scan mode;
    // the channel is (p / HOLD) mod N_CH.
    int          p   [3];
    bit          prv [3];
    logic [31:0] ey  [3];
    logic [31:0] es  [3];
    bit          ev  [3];
    bit          ew  [3];
    bit          ee  [3];
    bit          started = 1'b0;

    function automatic logic [31:0] ch(input int i, input int k);
        logic [31:0] m;
        m = (32'd1 << WS[i]) - 32'd1;
        return (32'(data_in) >> (k * WS[i])) & m;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int idx;
            int s;
            if (rst) begin
                p[i] = 0; prv[i] = 1'b0;
                ey[i] = 0; es[i] = 0;
                ev[i] = 1'b0; ew[i] = 1'b0; ee[i] = 1'b0;
            end else if (!en) begin
                ew[i] = 1'b0; ee[i] = 1'b0;
            end else if (mode) begin
                if (!prv[i]) begin
                    p[i] = 0;
                    ew[i] = 1'b0;
                end else begin
                    ew[i] = (p[i] == 0);
                end
                idx = (p[i] / HS[i]) % NCHS[i];
                ey[i] = ch(i, idx);
                es[i] = 32'(idx);
                ev[i] = 1'b1;
                ee[i] = 1'b0;
                p[i] = (p[i] + 1) % (NCHS[i] * HS[i]);
                prv[i] = 1'b1;
            end else begin
                s = int'(sel_in) & ((1 << SWS[i]) - 1);
                es[i] = 32'(s);
                ew[i] = 1'b0;
                if (s < NCHS[i]) begin
                    ey[i] = ch(i, s); ev[i] = 1'b1; ee[i] = 1'b0;
                end else begin
                    ey[i] = 0; ev[i] = 1'b0; ee[i] = 1'b1;
                end
                prv[i] = 1'b0;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_y%0d", i), dy[i], ey[i]);
                chk($sformatf("model_sel%0d", i), ds[i], es[i]);
                chk($sformatf("model_valid%0d", i), 32'(dv[i]), 32'(ev[i]));
                chk($sformatf("model_wrap%0d", i), 32'(dw[i]), 32'(ew[i]));
                chk($sformatf("model_err%0d", i), 32'(de[i]), 32'(ee[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0;
        sel_in = 3'd0; data_in = 20'h1;

        // Reset holds everything at zero
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_y", 32'(y0), 0);
            chk("rst_valid", 32'(v0), 0);
            chk("rst_sel", 32'(s0), 0);
            chk("rst_wrap", 32'(w0), 0);
        end
        rst = 1'b0;

        // Manual one-hot walk
        for (int s = 0; s < 4; s++) begin
            data_in = 20'(1 << s);
            sel_in  = 3'(s);
            tick();
            chk("man_y", 32'(y0), 1);
            chk("man_sel", 32'(s0), 32'(s));
        end
        data_in = 20'h0;
        tick();
        chk("man_zero_y", 32'(y0), 0);
        chk("man_zero_sel", 32'(s0), 3);

        // Scan with data 0101
        data_in = 20'h5;
        mode = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("h1_y", 32'(y0), 32'(k % 2 == 0));
            chk("h1_sel", 32'(s0), 32'(k % 4));
            chk("h1_wrap", 32'(w0), 32'(k != 0 && k % 4 == 0));
            chk("h3_sel", 32'(s1), 32'((k / 3) % 4));
            chk("h3_wrap", 32'(w1), 32'(k == 12));
        end
        tick();
        chk("h3_pre_freeze", 32'(s1), 1);

        // Freeze mid-dwell
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("frz_sel1", 32'(s1), 1);
            chk("frz_sel0", 32'(s0), 3);
            chk("frz_valid", 32'(v1), 1);
        end
        en = 1'b1;
        tick(); chk("resume_a", 32'(s1), 1);
        tick(); chk("resume_b", 32'(s1), 1);
        tick(); chk("resume_c", 32'(s1), 2);

        // Mode / reset interplay
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mi_scan_sel", 32'(s0), 32'(k));
        end
        mode = 1'b0; sel_in = 3'd3; data_in = 20'h8;
        tick();
        chk("mi_man_y", 32'(y0), 1);
        chk("mi_man_sel", 32'(s0), 3);
        mode = 1'b1;
        tick();
        chk("mi_reenter_sel", 32'(s0), 0);
        chk("mi_reenter_wrap", 32'(w0), 0);
        tick(); chk("mi_step1", 32'(s0), 1);
        tick(); chk("mi_step2", 32'(s0), 2);
        rst = 1'b1;
        tick();
        chk("mi_rst_y", 32'(y0), 0);
        chk("mi_rst_valid", 32'(v0), 0);
        chk("mi_rst_sel", 32'(s0), 0);
        chk("mi_rst_wrap", 32'(w0), 0);
        rst = 1'b0;
        tick();
        chk("mi_restart_sel", 32'(s0), 0);
        chk("mi_restart_wrap", 32'(w0), 0);
        chk("mi_restart_valid", 32'(v0), 1);

        // Five-channel build: out-of-range select
        mode = 1'b0; sel_in = 3'd6; data_in = 20'hA0000;
        tick();
        chk("n5_err", 32'(e2), 1);
        chk("n5_err_y", 32'(y2), 0);
        chk("n5_err_valid", 32'(v2), 0);
        chk("n5_err_sel", 32'(s2), 6);
        sel_in = 3'd4;
        tick();
        chk("n5_y", 32'(y2), 32'hA);
        chk("n5_valid", 32'(v2), 1);
        chk("n5_err_clr", 32'(e2), 0);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            rst     = ($urandom % 60) == 0;
            en      = ($urandom % 5) != 0;
            if (($urandom % 12) == 0) mode = ~mode;
            sel_in  = 3'($urandom);
            data_in = 20'($urandom);
            tick();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N-channel multiplexer. Generalises the team's 4x1 combinational mux.
- Two modes:
  - manual: external select.
  - scan: internal select counter steps through the channels, dwelling a programmable number of cycles on each.
- Feeds the time-multiplexed display/readout paths. Output is registered, with a valid flag, the current channel index and a wrap pulse.

Parameters:
- N_CH, 4, number of input channels (>=2).
- W, 1, width of each channel in bits.
- HOLD, 1, dwell cycles per channel in scan mode (>=1).
- SEL_W (localparam), $clog2(N_CH), select/index width.
- HOLD_W (localparam), $clog2(HOLD+1), dwell counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance/sample enable. When low, all state holds.
- mode  input  1  0 = manual, 1 = scan.
- sel_in  input  SEL_W  manual channel select.
- data_in  input  N_CH*W  flattened channels; channel k occupies bits [k*W +: W].
- y  output  W  registered selected channel.
- y_valid  output  1  high when y holds a legal sample.
- sel_out  output  SEL_W  channel index that produced the current y.
- wrap  output  1  one-cycle pulse when the scan index goes from N_CH-1 to 0.
- sel_err  output  1  one-cycle pulse when a manual select is out of range.

Behaviour:
- Reset values: y=0, y_valid=0, sel_out=0, wrap=0, sel_err=0. Internal scan index=0, dwell count=0.
- Reset has priority over en and mode, including mid-scan.
- All outputs are registered. Latency is 1 cycle from the sampling edge to y.
- en=0: y, sel_out, y_valid, scan index and dwell count all hold. wrap=0, sel_err=0.
- Manual mode (mode=0, en=1), at each edge:
  - sel_in < N_CH: y <= data_in[sel_in], sel_out <= sel_in, y_valid <= 1, sel_err <= 0.
  - sel_in >= N_CH (only possible when N_CH is not a power of 2): y <= 0, y_valid <= 0, sel_err <= 1, sel_out <= sel_in.
  - The scan index and dwell count are not modified.
- Scan mode (mode=1, en=1):
  - Each edge: y <= data_in[idx], sel_out <= idx, y_valid <= 1.
  - Dwell count increments each edge.
  - When dwell == HOLD-1: dwell <= 0, and idx <= (idx == N_CH-1) ? 0 : idx+1.
  - wrap <= 1 on the edge where idx goes from N_CH-1 to 0. Otherwise wrap <= 0.
  - HOLD=1 means the index advances every enabled cycle.
- Mode change manual -> scan, detected on the edge where the registered previous mode=0 and mode=1:
  - idx and dwell restart at 0.
  - That edge samples channel 0.
  - No wrap pulse is generated.
- Mode change scan -> manual: takes effect the same edge; sel_in is used immediately.
- The dwell/index state is frozen while en=0 and resumes with no skipped channel.
- Channel data changing mid-dwell is reflected in y on the next edge (the mux is resampled every enabled cycle, not latched once per dwell).
- Widths: idx wraps strictly at N_CH, never at 2^SEL_W. All comparisons are unsigned.

Decomposition:
- Shared include file (mux_defs.vh) holds:
  - `define MODE_MANUAL 1'b0 and `define MODE_SCAN 1'b1.
  - A CLOG2 helper macro for pre-2005 tools.
- One sub-module, scan_counter (params N_CH, HOLD):
  - Inputs: clk, rst, en, restart.
  - Outputs: idx, wrap_next.
  - Contains the dwell and index counters.
- mux_scan holds the previous-mode register, the output registers and the selection logic (indexed part-select on data_in).

Test Plan (N_CH=4, W=1, HOLD=1 unless stated; data_in = {d,c,b,a}):
- Reset: rst=1 for 2 cycles with a=1, en=1 -> y=0, y_valid=0, sel_out=0, wrap=0 throughout. Release rst.
- Manual select:
  - mode=0, sel_in=0..3 sequentially, with one-hot data following the channel ({0,0,0,1}, {0,0,1,0}, ...) -> y=1 one cycle after each change.
  - Zero the selected channel -> y=0 next cycle; sel_out tracks sel_in.
- Scan, HOLD=1, data_in=4'b0101:
  - y sequence 1,0,1,0,1... with sel_out 0,1,2,3,0.
  - wrap high exactly on the cycle sel_out returns to 0 (every 4th cycle).
- Scan, HOLD=3:
  - Each sel_out value persists 3 cycles.
  - wrap period 12 cycles.
  - Drop en for 5 cycles mid-dwell -> all outputs frozen; the dwell resumes with the remaining count.
- Mode/reset interplay:
  - Scan to idx=2, switch to manual with sel_in=3 -> next y=d.
  - Switch back to scan -> sel_out=0 on the first edge, no wrap.
  - Assert rst at idx=2 -> next-cycle outputs all 0, scan restarts at 0.
- N_CH=5 build, manual sel_in=6 -> sel_err pulses 1 cycle, y=0, y_valid=0. sel_in=4 -> y=data_in[4], y_valid=1.
